dup_range_pairs: RTL and testbench
==================================

DUP_RANGE_PAIRS -- requirements
Module: dup_range_pairs

Interface
REQ-001 Ports SHALL be, in order:
- `_clock` in, 1: single clock, all logic on posedge.
- `_reset` in, 1: synchronous, active-high reset.
- `base` in, 32 signed: first counter value, forwarded to the producer.
- `limit` in, 32 signed: exclusive upper bound, forwarded.
- `step` in, 32 signed: counter increment, forwarded.
- `_start` in, 1: capture inputs in the same cycle and begin.
- `_ready` in, 1: caller accepts output this cycle.
- `_valid` out, 1 (reg): `_0`/`_1` hold a valid tuple.
- `_done` out, 1 (reg): block finished outputting.
- `_0` out, 32 signed (reg): pair sum.
- `_1` out, 32 signed (reg): pair index.
REQ-002 The block SHALL have one clock, `_clock`, and its reset `_reset` SHALL be synchronous and active-high.
REQ-003 Output handshake SHALL be ready/valid: a tuple transfers on a posedge where `_valid && _ready`.

Function
REQ-004 The block SHALL consume the `dup_range(base, limit, step)` stream and yield one tuple per consecutive pair (a, b): `_0 = a + b`, `_1 = k`, where k counts emitted tuples from 0.
REQ-005 If the stream ends with an unpaired value a, the block SHALL emit one final tuple `(a, k)`.
REQ-006 Arithmetic SHALL be 32-bit signed two's-complement with wrap; sum and k SHALL be truncated to 32 bits.
REQ-007 Internal producer handshake:
- Producer `_start` and argument ports SHALL be driven directly from `_start`/`base`/`limit`/`step`.
- Producer `_reset` SHALL be driven from `_reset`.
- Producer `_ready` SHALL be high only in GET_A and GET_B.
REQ-008 State machine with transitions:
- DONE: `_done <= 1` every cycle in which `_valid` is low or `_ready` is high.
- GET_A: producer valid&ready -> latch a, go GET_B; producer `_done` -> DONE.
- GET_B: producer valid&ready -> latch b, go EMIT; producer `_done` -> EMIT_ODD.
- EMIT: `_0 <= a+b`, `_1 <= k`, `_valid <= 1`, `k <= k+1`, go GET_A.
- EMIT_ODD: `_0 <= a`, `_1 <= k`, `_valid <= 1`, go DONE.
REQ-009 Each cycle `_done` SHALL default to 0; when `_ready` is high, `_valid` SHALL default to 0 unless set in that cycle.
REQ-010 State advance SHALL occur only when `_ready || !_valid`; otherwise all registers, including `_0`/`_1`/`_valid`, SHALL hold.
REQ-011 On `_start`: state <= GET_A, k <= 0, `_valid <= 0`. Latency SHALL be start posedge to first `_valid` ≤ 8 cycles with `_ready` held high.
REQ-012 `_start` SHALL take precedence over `_reset` in the same cycle; `_start` mid-operation SHALL abandon any pending pair and restart.
REQ-013 A stream with base ≥ limit SHALL produce no tuples; `_done` SHALL assert within 4 cycles of `_start`.
REQ-014 Producer `_done` SHALL be evaluated only in GET_A/GET_B and ignored in all other states.

Reset
REQ-015 On `_reset` (no `_start`), the block SHALL set state <= DONE, `_valid <= 0`, `_0 <= 0`, `_1 <= 0`, k <= 0, a <= 0, b <= 0.
REQ-016 `_done` SHALL be 0 in the reset cycle and 1 from the next cycle while idle.
REQ-017 Reset mid-operation SHALL discard any pending tuple, with no further `_valid` until `_start`.

Structure
REQ-018 State encodings SHALL be localparams inside the module; the codebase has no shared package and none is added.
REQ-019 The block SHALL contain exactly one sub-module instance: `dup_range`, as the producer.
REQ-020 State, a, b and k SHALL be registers of 32 signed bits.

Verification
REQ-021 start (0,10,2), `_ready` = 1 -> 5 tuples `(0,0)..(0,4)`, then `_done` = 1, `_valid` never high again.
REQ-022 start (5,5,1) -> no `_valid`; `_done` = 1 within 4 cycles.
REQ-023 start (0,10,2), `_ready` toggled 1-0-1 -> `_0`/`_1` stable while `_valid && !_ready`; exactly 5 transfers, k = 0..4, none lost or duplicated.
REQ-024 `_reset` after 2nd transfer of (0,10,2) -> `_valid` = 0 the next cycle, `_done` = 1 the cycle after; new start (0,4,2) -> 2 tuples `(0,0)`, `(0,1)`.
REQ-025 `_start` and `_reset` high together with (0,6,3) -> start wins; 2 tuples `(0,0)`, `(0,1)`, then done.
REQ-026 Odd-tail path, using a forced 3-value producer stream (7, 8, 9) -> tuples `(15,0)`, `(9,1)`, then done.

Source files
------------

// File: rtl/dup_range_pairs_range.sv
// dup_range: producer that walks base, base+step, ... while below limit,
// presenting every range value v as two stream items, v then -v.
// Ports: _clock/_reset/_start control; base/limit/step arguments captured
// on _start; _valid/_ready/_0 carry one item per handshake; _done flags
// the end of the stream.
module dup_range (
    input  logic               _clock,
    input  logic               _reset,
    input  logic signed [31:0] base,
    input  logic signed [31:0] limit,
    input  logic signed [31:0] step,
    input  logic               _start,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _0
);

    logic signed [31:0] cur_q, cur_d;
    logic signed [31:0] lim_q, lim_d;
    logic signed [31:0] stp_q, stp_d;
    logic               neg_q, neg_d;
    logic               run_q, run_d;
    logic               more;

    always_comb begin
        more   = run_q && (cur_q < lim_q);
        _valid = more;
        _done  = run_q && !more;
        _0     = neg_q ? -cur_q : cur_q;

        cur_d = cur_q;
        lim_d = lim_q;
        stp_d = stp_q;
        neg_d = neg_q;
        run_d = run_q;

        if (_start) begin
            cur_d = base;
            lim_d = limit;
            stp_d = step;
            neg_d = 1'b0;
            run_d = 1'b1;
        end else if (_reset) begin
            cur_d = '0;
            lim_d = '0;
            stp_d = '0;
            neg_d = 1'b0;
            run_d = 1'b0;
        end else if (more && _ready) begin
            // second copy of a value consumed: move to the next value
            if (neg_q) begin
                neg_d = 1'b0;
                cur_d = cur_q + stp_q;
            end else begin
                neg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge _clock) begin
        cur_q <= cur_d;
        lim_q <= lim_d;
        stp_q <= stp_d;
        neg_q <= neg_d;
        run_q <= run_d;
    end

endmodule

// File: rtl/dup_range_pairs.sv
// dup_range_pairs: pairs consecutive items of the dup_range stream and
// emits (a+b, k) per pair, or (a, k) for an unpaired tail item.
// Ports: _clock, _reset (sync, active-high), _start with base/limit/step,
// _ready in; _valid, _done, _0 (sum), _1 (pair index) out.
module dup_range_pairs (
    input  logic               _clock,
    input  logic               _reset,
    input  logic signed [31:0] base,
    input  logic signed [31:0] limit,
    input  logic signed [31:0] step,
    input  logic               _start,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _0,
    output logic signed [31:0] _1
);

    localparam logic signed [31:0] S_DONE     = 32'sd0;
    localparam logic signed [31:0] S_GET_A    = 32'sd1;
    localparam logic signed [31:0] S_GET_B    = 32'sd2;
    localparam logic signed [31:0] S_EMIT     = 32'sd3;
    localparam logic signed [31:0] S_EMIT_ODD = 32'sd4;

    logic signed [31:0] state_q, state_d;
    logic signed [31:0] a_q, a_d;
    logic signed [31:0] b_q, b_d;
    logic signed [31:0] k_q, k_d;
    logic signed [31:0] sum_q, sum_d;
    logic signed [31:0] idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               p_valid;
    logic               p_done;
    logic               p_ready;
    logic signed [31:0] p_data;
    logic               advance;

    // registers only move when the output slot is free or being drained
    assign advance = _ready || !valid_q;

    // pull from the producer only when this cycle will actually latch it
    assign p_ready = !_start && !_reset && advance &&
                     (state_q == S_GET_A || state_q == S_GET_B);

    dup_range u_prod (
        ._clock (_clock),
        ._reset (_reset),
        .base   (base),
        .limit  (limit),
        .step   (step),
        ._start (_start),
        ._ready (p_ready),
        ._valid (p_valid),
        ._done  (p_done),
        ._0     (p_data)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (_start) begin
            state_d = S_GET_A;
            k_d     = '0;
            valid_d = 1'b0;
        end else if (_reset) begin
            state_d = S_DONE;
            a_d     = '0;
            b_d     = '0;
            k_d     = '0;
            sum_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (advance) begin
            if (_ready) begin
                valid_d = 1'b0;
            end
            case (state_q)
                S_DONE: begin
                    done_d = 1'b1;
                end
                S_GET_A: begin
                    if (p_valid) begin
                        a_d     = p_data;
                        state_d = S_GET_B;
                    end else if (p_done) begin
                        state_d = S_DONE;
                    end
                end
                S_GET_B: begin
                    if (p_valid) begin
                        b_d     = p_data;
                        state_d = S_EMIT;
                    end else if (p_done) begin
                        state_d = S_EMIT_ODD;
                    end
                end
                S_EMIT: begin
                    sum_d   = a_q + b_q;
                    idx_d   = k_q;
                    valid_d = 1'b1;
                    k_d     = k_q + 32'sd1;
                    state_d = S_GET_A;
                end
                S_EMIT_ODD: begin
                    sum_d   = a_q;
                    idx_d   = k_q;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge _clock) begin
        state_q <= state_d;
        a_q     <= a_d;
        b_q     <= b_d;
        k_q     <= k_d;
        sum_q   <= sum_d;
        idx_q   <= idx_d;
        valid_q <= valid_d;
        done_q  <= done_d;
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _0     = sum_q;
    assign _1     = idx_q;

endmodule

// File: tb/tb_dup_range_pairs.sv
// Testbench for dup_range_pairs: directed scenarios plus randomized streams
// with random back-pressure, compared against a queue-based stream model.
module tb_dup_range_pairs;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               ready;
    logic signed [31:0] base_i;
    logic signed [31:0] limit_i;
    logic signed [31:0] step_i;
    logic               valid_o;
    logic               done_o;
    logic signed [31:0] o0;
    logic signed [31:0] o1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    dup_range_pairs u_dut (
        ._clock (clk),
        ._reset (rst),
        .base   (base_i),
        .limit  (limit_i),
        .step   (step_i),
        ._start (start),
        ._ready (ready),
        ._valid (valid_o),
        ._done  (done_o),
        ._0     (o0),
        ._1     (o1)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: range values v each appear as v, -v; consecutive items
    // are summed pairwise, a lone tail item is passed through.
    function automatic void build_model(int b, int l, int s);
        int items[$];
        exp_q.delete();
        for (int v = b; v < l; v += s) begin
            items.push_back(v);
            items.push_back(-v);
        end
        for (int i = 0; i < items.size(); i += 2) begin
            if (i + 1 < items.size())
                exp_q.push_back(items[i] + items[i+1]);
            else
                exp_q.push_back(items[i]);
        end
    endfunction

    // mode 0: ready high, 1: ready toggles, 2: random ready
    task automatic run_stream(input int b, input int l, input int s,
                              input int mode, input bit with_rst);
        int got = 0;
        int cyc = 0;
        int first = -1;
        bit stall = 0;
        logic signed [31:0] h0 = 0;
        logic signed [31:0] h1 = 0;
        build_model(b, l, s);
        @(negedge clk);
        base_i  = b;
        limit_i = l;
        step_i  = s;
        start   = 1'b1;
        rst     = with_rst;
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        while (cyc < 2000 && !(done_o && got == exp_q.size())) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 0);
                default: ready = 1'($urandom % 2);
            endcase
            if (stall) begin
                check("hold_sum", o0, h0);
                check("hold_idx", o1, h1);
            end
            if (valid_o && first < 0) first = cyc;
            if (valid_o && ready) begin
                if (got < exp_q.size()) begin
                    check("sum", o0, exp_q[got]);
                    check("idx", o1, got);
                end else begin
                    check("extra_valid", 1'b1, 1'b0);
                end
                got++;
            end
            stall = valid_o && !ready;
            h0    = o0;
            h1    = o1;
            @(negedge clk);
            cyc++;
        end
        check("count", got, exp_q.size());
        check("done", done_o, 1'b1);
        if (mode == 0 && exp_q.size() > 0) check("latency_ok", first <= 8, 1'b1);
        if (exp_q.size() == 0) check("empty_done_ok", cyc <= 4, 1'b1);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("quiet_valid", valid_o, 1'b0);
        end
    endtask

    initial begin
        int got;
        int cyc;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b1;
        base_i  = 0;
        limit_i = 0;
        step_i  = 0;

        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_sum", o0, 0);
        check("rst_idx", o1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", done_o, 1'b1);

        run_stream(0, 10, 2, 0, 1'b0);
        run_stream(5, 5, 1, 0, 1'b0);
        run_stream(0, 10, 2, 1, 1'b0);

        // reset after the second transfer discards the rest
        @(negedge clk);
        base_i  = 0;
        limit_i = 10;
        step_i  = 2;
        start   = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        cyc   = 0;
        while (got < 2 && cyc < 50) begin
            if (valid_o) begin
                check("mid_sum", o0, 0);
                check("mid_idx", o1, got);
                got++;
            end
            if (got < 2) @(negedge clk);
            cyc++;
        end
        check("mid_count", got, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", valid_o, 1'b0);
        @(negedge clk);
        check("mid_rst_done", done_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_quiet", valid_o, 1'b0);
        end
        run_stream(0, 4, 2, 0, 1'b0);

        // start and reset together: start wins
        run_stream(0, 6, 3, 0, 1'b1);

        // odd tail: override the producer with the items 7, 8, 9
        force u_dut.p_valid = 1'b0;
        force u_dut.p_done  = 1'b0;
        force u_dut.p_data  = 32'sd0;
        @(negedge clk);
        base_i  = 5;
        limit_i = 5;
        step_i  = 1;
        start   = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        force u_dut.p_valid = 1'b1;
        force u_dut.p_data  = 32'sd7;
        @(negedge clk);
        force u_dut.p_data  = 32'sd8;
        @(negedge clk);
        force u_dut.p_valid = 1'b0;
        @(negedge clk);
        check("odd_v0", valid_o, 1'b1);
        check("odd_sum0", o0, 15);
        check("odd_idx0", o1, 0);
        force u_dut.p_valid = 1'b1;
        force u_dut.p_data  = 32'sd9;
        @(negedge clk);
        force u_dut.p_valid = 1'b0;
        force u_dut.p_done  = 1'b1;
        @(negedge clk);
        force u_dut.p_done  = 1'b0;
        @(negedge clk);
        check("odd_v1", valid_o, 1'b1);
        check("odd_sum1", o0, 9);
        check("odd_idx1", o1, 1);
        release u_dut.p_valid;
        release u_dut.p_done;
        release u_dut.p_data;
        @(negedge clk);
        check("odd_done", done_o, 1'b1);
        check("odd_quiet", valid_o, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int b;
            int l;
            int s;
            b = int'($urandom_range(0, 100)) - 50;
            l = b + int'($urandom_range(0, 35)) - 5;
            s = int'($urandom_range(1, 6));
            run_stream(b, l, s, 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
